// File: rtl/ccc_supervisor_pkg.sv
// Shared types and defaults for the clock-domain channel supervisor.
// Holds the FSM encoding and the parameter defaults used by all files.
package ccc_supervisor_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } sup_state_e;

  localparam int NUM_CH_D        = 4;
  localparam int DIV_W_D         = 8;
  localparam int STABLE_CYCLES_D = 1024;
  localparam int STAGGER_D       = 16;
  localparam int LOSS_W_D        = 8;

  // Counter width able to hold 0..last
  function automatic int cnt_w(input int last);
    return (last < 1) ? 1 : $clog2(last + 1);
  endfunction

endpackage

// File: rtl/ccc_ce_div.sv
// Per-channel clock-enable divider.
// Emits a one-cycle ce pulse every ratio+1 cycles while enabled.
module ccc_ce_div
  import ccc_supervisor_pkg::*;
#(
  parameter int DIV_W = DIV_W_D
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             enable,
  input  logic [DIV_W-1:0] ratio,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_q;

  // >= rather than == so a ratio decrease never strands the counter
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q <= '0;
      ce    <= 1'b0;
    end else if (!enable) begin
      cnt_q <= '0;
      ce    <= 1'b0;
    end else if (cnt_q >= ratio) begin
      cnt_q <= '0;
      ce    <= 1'b1;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
      ce    <= 1'b0;
    end
  end

endmodule

// File: rtl/ccc_supervisor.sv
// PLL lock supervisor: waits for stable lock, releases channel resets
// in a staggered order, and drives per-channel clock enables.
module ccc_supervisor
  import ccc_supervisor_pkg::*;
#(
  parameter int NUM_CH        = NUM_CH_D,
  parameter int DIV_W         = DIV_W_D,
  parameter int STABLE_CYCLES = STABLE_CYCLES_D,
  parameter int STAGGER       = STAGGER_D,
  parameter int LOSS_W        = LOSS_W_D
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    PLL_LOCK,
  input  logic [NUM_CH*DIV_W-1:0] DIV_RATIO,
  input  logic                    CLR_LOSS,
  output logic [NUM_CH-1:0]       CH_RESETN,
  output logic [NUM_CH-1:0]       CH_CE,
  output logic                    READY,
  output logic [LOSS_W-1:0]       LOCK_LOSS_CNT
);

  localparam int SC_W     = cnt_w(STABLE_CYCLES - 1);
  localparam int REL_LAST = (NUM_CH - 1) * STAGGER;
  localparam int RC_W     = cnt_w(REL_LAST);

  localparam logic [SC_W-1:0] STAB_END = SC_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0] REL_END  = RC_W'(REL_LAST);

  logic              sync1;
  logic              lock_s;
  sup_state_e        state_q;
  sup_state_e        state_d;
  logic [SC_W-1:0]   stab_q;
  logic [SC_W-1:0]   stab_d;
  logic [RC_W-1:0]   rel_q;
  logic [RC_W-1:0]   rel_d;
  logic [NUM_CH-1:0] rstn_q;
  logic [NUM_CH-1:0] rstn_d;
  logic              ready_q;
  logic              ready_d;
  logic              loss_ev;
  logic [LOSS_W-1:0] loss_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= PLL_LOCK;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
      rel_q   <= '0;
      rstn_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      rel_q   <= rel_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    rel_d   = rel_q;
    loss_ev = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        stab_d = '0;
        rel_d  = '0;
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_END) begin
          state_d = RELEASE;
          stab_d  = '0;
          rel_d   = '0;
        end else begin
          stab_d = stab_q + SC_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rel_d   = '0;
          loss_ev = 1'b1;
        end else if (rel_q == REL_END) begin
          state_d = RUN;
        end else begin
          rel_d = rel_q + RC_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rel_d   = '0;
          loss_ev = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Outputs are computed from next state so they are registered yet aligned
  always_comb begin
    rstn_d  = '0;
    ready_d = (state_d == RUN);
    for (int i = 0; i < NUM_CH; i++) begin
      rstn_d[i] = (state_d == RUN) ||
                  ((state_d == RELEASE) &&
                   (rel_d >= RC_W'(i * STAGGER)));
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      loss_q <= '0;
    end else if (CLR_LOSS) begin
      loss_q <= '0;
    end else if (loss_ev && !(&loss_q)) begin
      loss_q <= loss_q + LOSS_W'(1);
    end
  end

  // Dividers see the reset D-value so CE drops on the same edge as CH_RESETN
  for (genvar g = 0; g < NUM_CH; g++) begin : g_div
    ccc_ce_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .CLK    (CLK),
      .RESETN (RESETN),
      .enable (rstn_d[g]),
      .ratio  (DIV_RATIO[g*DIV_W +: DIV_W]),
      .ce     (CH_CE[g])
    );
  end

  assign CH_RESETN     = rstn_q;
  assign READY         = ready_q;
  assign LOCK_LOSS_CNT = loss_q;

endmodule

// File: tb/tb_ccc_supervisor.sv
// Directed bench for ccc_supervisor with 3 channels, short stability
// window and a 2-bit loss counter.
module tb_ccc_supervisor;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int LOSS_W = 2;

  logic                    CLK;
  logic                    RESETN;
  logic                    PLL_LOCK;
  logic [NUM_CH*DIV_W-1:0] DIV_RATIO;
  logic                    CLR_LOSS;
  logic [NUM_CH-1:0]       CH_RESETN;
  logic [NUM_CH-1:0]       CH_CE;
  logic                    READY;
  logic [LOSS_W-1:0]       LOCK_LOSS_CNT;

  int tests = 0;
  int fails = 0;

  ccc_supervisor #(
    .NUM_CH        (NUM_CH),
    .DIV_W         (DIV_W),
    .STABLE_CYCLES (8),
    .STAGGER       (4),
    .LOSS_W        (LOSS_W)
  ) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .PLL_LOCK      (PLL_LOCK),
    .DIV_RATIO     (DIV_RATIO),
    .CLR_LOSS      (CLR_LOSS),
    .CH_RESETN     (CH_RESETN),
    .CH_CE         (CH_CE),
    .READY         (READY),
    .LOCK_LOSS_CNT (LOCK_LOSS_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects PLL_LOCK just raised with the synchroniser and FSM idle
  task automatic rel_seq(input string tag);
    tick(10);
    chk({tag, "_pre"}, 32'(CH_RESETN), 32'h0);
    tick(1);
    chk({tag, "_ch0"}, 32'(CH_RESETN), 32'h1);
    tick(3);
    chk({tag, "_ch0_hold"}, 32'(CH_RESETN), 32'h1);
    tick(1);
    chk({tag, "_ch1"}, 32'(CH_RESETN), 32'h3);
    tick(3);
    chk({tag, "_ch1_hold"}, 32'(CH_RESETN), 32'h3);
    tick(1);
    chk({tag, "_ch2"}, 32'(CH_RESETN), 32'h7);
    chk({tag, "_rdy_lo"}, 32'(READY), 32'h0);
    tick(1);
    chk({tag, "_rdy_hi"}, 32'(READY), 32'h1);
  endtask

  task automatic loss_in_release(input logic [1:0] exp_cnt);
    PLL_LOCK = 1'b1;
    tick(11);
    PLL_LOCK = 1'b0;
    tick(2);
    chk("rel_still_on", 32'(CH_RESETN), 32'h1);
    tick(1);
    chk("rel_loss_rstn", 32'(CH_RESETN), 32'h0);
    chk("rel_loss_cnt", 32'(LOCK_LOSS_CNT), 32'(exp_cnt));
  endtask

  int n0;
  int n1;
  int n2;
  bit found;

  initial begin
    RESETN    = 1'b0;
    PLL_LOCK  = 1'b0;
    CLR_LOSS  = 1'b0;
    DIV_RATIO = {8'd0, 8'd1, 8'd3};
    #12;
    chk("rst_rstn", 32'(CH_RESETN), 32'h0);
    chk("rst_ce", 32'(CH_CE), 32'h0);
    chk("rst_ready", 32'(READY), 32'h0);
    chk("rst_loss", 32'(LOCK_LOSS_CNT), 32'h0);
    RESETN = 1'b1;
    tick(2);
    chk("idle_rstn", 32'(CH_RESETN), 32'h0);

    // Glitch on STABLE cycle 5 restarts the window
    PLL_LOCK = 1'b1;
    tick(6);
    PLL_LOCK = 1'b0;
    tick(1);
    PLL_LOCK = 1'b1;
    tick(4);
    chk("glitch_no_rel", 32'(CH_RESETN), 32'h0);
    tick(6);
    chk("glitch_no_rel2", 32'(CH_RESETN), 32'h0);
    chk("glitch_loss", 32'(LOCK_LOSS_CNT), 32'h0);
    tick(1);
    chk("glitch_ch0", 32'(CH_RESETN), 32'h1);
    tick(4);
    chk("glitch_ch1", 32'(CH_RESETN), 32'h3);
    tick(4);
    chk("glitch_ch2", 32'(CH_RESETN), 32'h7);
    tick(1);
    chk("glitch_ready", 32'(READY), 32'h1);

    // CE rates over an 8-cycle window
    n0 = 0;
    n1 = 0;
    n2 = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      n0 += int'(CH_CE[0]);
      n1 += int'(CH_CE[1]);
      n2 += int'(CH_CE[2]);
    end
    chk("ce0_rate", 32'(n0), 32'd2);
    chk("ce1_rate", 32'(n1), 32'd4);
    chk("ce2_rate", 32'(n2), 32'd8);

    // Ratio 3 -> 1 while ch0 counter sits at 2
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick(1);
      found = CH_CE[0];
    end
    chk("ce0_found", 32'(found), 32'h1);
    tick(2);
    chk("ce0_mid_lo", 32'(CH_CE[0]), 32'h0);
    DIV_RATIO = {8'd0, 8'd1, 8'd1};
    tick(1);
    chk("ce0_dec_pulse", 32'(CH_CE[0]), 32'h1);
    tick(1);
    chk("ce0_dec_lo", 32'(CH_CE[0]), 32'h0);
    tick(1);
    chk("ce0_dec_hi", 32'(CH_CE[0]), 32'h1);

    // Lock loss in RUN
    PLL_LOCK = 1'b0;
    tick(2);
    chk("run_ready_kept", 32'(READY), 32'h1);
    tick(1);
    chk("run_loss_rstn", 32'(CH_RESETN), 32'h0);
    chk("run_loss_ce", 32'(CH_CE), 32'h0);
    chk("run_loss_ready", 32'(READY), 32'h0);
    chk("run_loss_cnt", 32'(LOCK_LOSS_CNT), 32'h1);
    PLL_LOCK = 1'b1;
    rel_seq("relock");

    PLL_LOCK = 1'b0;
    tick(3);
    chk("loss2", 32'(LOCK_LOSS_CNT), 32'h2);
    loss_in_release(2'd3);
    loss_in_release(2'd3);

    // Fifth loss coincident with clear
    PLL_LOCK = 1'b1;
    tick(11);
    PLL_LOCK = 1'b0;
    tick(2);
    CLR_LOSS = 1'b1;
    tick(1);
    CLR_LOSS = 1'b0;
    chk("clr_wins", 32'(LOCK_LOSS_CNT), 32'h0);
    chk("clr_rstn", 32'(CH_RESETN), 32'h0);

    // Asynchronous reset mid-RELEASE
    PLL_LOCK = 1'b1;
    tick(13);
    chk("pre_arst", 32'(CH_RESETN), 32'h1);
    #2;
    RESETN = 1'b0;
    #1;
    chk("arst_rstn", 32'(CH_RESETN), 32'h0);
    chk("arst_ce", 32'(CH_CE), 32'h0);
    chk("arst_ready", 32'(READY), 32'h0);
    tick(2);
    RESETN = 1'b1;
    rel_seq("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
